// File: rtl/ro_deframer.sv
// ro_deframer: receive-side slot decoder for the gray-scheduled readout bus.
// A local binary counter mirrors the core-side gray schedule. The number of
// trailing ones in the counter names the channel that owns the current cycle.
// Non-empty slots become timestamped records in a small FIFO drained by a
// valid/ready consumer.
//
// Handshake: rec_valid is high whenever the FIFO holds a record and rec_data
// shows the head record. The head is consumed on a rising edge where
// rec_valid and rec_ready are both 1. rec_data is held steady while
// rec_valid=1 and rec_ready=0. An empty FIFO ignores rec_ready.
module ro_deframer #(
  parameter int NCH      = 10,
  parameter int TS_W     = 8,
  parameter int DEPTH    = 8,
  parameter int EMIT_ALL = 0
) (
  input  logic                       clk_master,
  input  logic                       rst,
  input  logic                       sync,
  input  logic [1:0]                 read_in_I,
  input  logic [1:0]                 read_in_Q,
  output logic [TS_W+7:0]            rec_data,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 8;
  localparam logic [AW:0] L_FULL = DEPTH[AW:0];

  logic [NCH-1:0]  r_cnt;
  logic [TS_W-1:0] r_ts;
  logic [RW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_fill;
  logic            r_overflow;
  logic [7:0]      r_drop_cnt;

  logic [NCH-1:0]  w_cnt_eff;
  logic [3:0]      w_ch;
  logic            w_stop;
  logic            w_idle;
  logic            w_any;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;
  logic [RW-1:0]   w_rec;

  // A sync pulse makes the current cycle behave as slot cnt=0.
  assign w_cnt_eff = sync ? '0 : r_cnt;
  assign w_idle    = &w_cnt_eff;
  assign w_any     = |{read_in_I, read_in_Q};

  // Channel index is the count of trailing ones in the effective counter.
  always_comb begin
    w_ch   = 4'd0;
    w_stop = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_stop && w_cnt_eff[i]) begin
        w_ch = w_ch + 4'd1;
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  assign w_rec  = {r_ts, w_ch, read_in_Q[1], read_in_Q[0], read_in_I[1], read_in_I[0]};
  assign w_push = !w_idle && ((EMIT_ALL != 0) || w_any);
  assign w_full = (r_fill == L_FULL);
  assign w_pop  = (r_fill != '0) && rec_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // Slot counter and frame timestamp; ts advances only on a natural wrap.
  always_ff @(posedge clk_master) begin
    if (rst) begin
      r_cnt <= '0;
      r_ts  <= '0;
    end else begin
      r_cnt <= w_cnt_eff + NCH'(1);
      if (!sync && (&r_cnt)) begin
        r_ts <= r_ts + TS_W'(1);
      end
    end
  end

  // Record storage; contents are only observable through valid pointers.
  always_ff @(posedge clk_master) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_master) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_master) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign rec_valid = (r_fill != '0);
  assign rec_data  = rec_valid ? r_mem[r_rd_ptr] : '0;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign fill      = r_fill;

endmodule

// File: tb/tb_ro_deframer.sv
// tb_ro_deframer: directed scoreboard bench for ro_deframer.
// Two instances share the readout inputs: a sparse one (EMIT_ALL=0) and an
// emit-every-slot one (EMIT_ALL=1) used for the timestamp/frame checks.
module tb_ro_deframer;

  localparam int NCH   = 10;
  localparam int TS_W  = 8;
  localparam int DEPTH = 8;
  localparam int RW    = TS_W + 8;
  localparam int IDLE  = (1 << NCH) - 1;

  // ---------------- clock / reset ----------------
  logic clk_master = 1'b0;
  always #5 clk_master = ~clk_master;

  logic          rst, rst_all, sync, rec_ready, all_ready;
  logic [1:0]    read_in_I, read_in_Q;
  logic [RW-1:0] rec_data, a_rec_data;
  logic          rec_valid, a_rec_valid;
  logic          overflow, a_overflow;
  logic [7:0]    drop_cnt, a_drop_cnt;
  logic [3:0]    fill, a_fill;

  ro_deframer #(.NCH(NCH), .TS_W(TS_W), .DEPTH(DEPTH), .EMIT_ALL(0)) dut (
    .clk_master(clk_master), .rst(rst), .sync(sync),
    .read_in_I(read_in_I), .read_in_Q(read_in_Q),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .overflow(overflow), .drop_cnt(drop_cnt), .fill(fill)
  );

  ro_deframer #(.NCH(NCH), .TS_W(TS_W), .DEPTH(DEPTH), .EMIT_ALL(1)) dut_all (
    .clk_master(clk_master), .rst(rst_all), .sync(sync),
    .read_in_I(read_in_I), .read_in_Q(read_in_Q),
    .rec_data(a_rec_data), .rec_valid(a_rec_valid), .rec_ready(all_ready),
    .overflow(a_overflow), .drop_cnt(a_drop_cnt), .fill(a_fill)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_all_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int all_pops = 0;
  int tb_cnt, tb_ts, m_fill, m_drop;
  bit all_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] t_ones(input int v);
    int n;
    n = 0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) n++;
      else break;
    end
    return n[3:0];
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs at a negedge, predicts pushes/drops/pops
  // from a reference occupancy, then advances the slot/timestamp model.
  task automatic slot(input logic s, input logic [1:0] i, input logic [1:0] q);
    int eff;
    logic pop_now;
    logic [RW-1:0] rec;
    logic [TS_W-1:0] ts_v;
    eff = s ? 0 : tb_cnt;
    sync = s;
    read_in_I = i;
    read_in_Q = q;
    pop_now = rec_ready && (m_fill > 0);
    if (eff != IDLE) begin
      ts_v = tb_ts[TS_W-1:0];
      rec = {ts_v, t_ones(eff), q, i};
      if (i != 2'b00 || q != 2'b00) begin
        if (m_fill == DEPTH && !pop_now) m_drop++;
        else begin
          exp_q.push_back(rec);
          m_fill++;
        end
      end
      if (all_en) exp_all_q.push_back(rec);
    end
    if (pop_now) m_fill--;
    @(posedge clk_master);
    tb_cnt = (eff + 1) % (1 << NCH);
    if (!s && eff == IDLE) tb_ts = (tb_ts + 1) % (1 << TS_W);
    @(negedge clk_master);
    sync = 1'b0;
    read_in_I = 2'b00;
    read_in_Q = 2'b00;
  endtask

  task automatic model_reset();
    exp_q.delete();
    tb_cnt = 0;
    tb_ts  = 0;
    m_fill = 0;
    m_drop = 0;
  endtask

  // ---------------- monitor ----------------
  // Samples 2 time units after the falling edge, once stimulus has settled.
  always @(negedge clk_master) begin
    #2;
    if (!rst && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rec_unexpected: got %h expected none at %0t", rec_data, $time);
      end else begin
        check("rec_data", 32'(rec_data), 32'(exp_q.pop_front()));
      end
    end
    if (!rst_all && a_rec_valid) begin
      all_pops++;
      if (exp_all_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL all_unexpected: got %h expected none at %0t", a_rec_data, $time);
      end else begin
        check("all_rec_data", 32'(a_rec_data), 32'(exp_all_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rst_all = 1'b1; sync = 1'b0; all_ready = 1'b1;
    read_in_I = 2'b11; read_in_Q = 2'b00; rec_ready = 1'b0; all_en = 0;
    model_reset();

    // Reset holds everything empty even with active inputs.
    repeat (2) begin
      @(posedge clk_master);
      @(negedge clk_master);
      check("rst_valid", 32'(rec_valid), 32'd0);
      check("rst_fill", 32'(fill), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_all_valid", 32'(a_rec_valid), 32'd0);
    end
    rst = 1'b0; rst_all = 1'b0; read_in_I = 2'b00;
    model_reset();
    all_en = 1;
    rec_ready = 1'b1;

    // Two full frames of silence: sparse instance emits nothing, emit-all
    // instance emits 1023 records per frame with ts 0 then 1.
    for (int k = 0; k < 2048; k++) slot(1'b0, 2'b00, 2'b00);
    all_en = 0;
    rst_all = 1'b1;
    check("all_count", 32'(all_pops), 32'd2046);
    check("sparse_fill", 32'(fill), 32'd0);
    check("model_ts", 32'(tb_ts), 32'd2);

    // Slot decode after sync: cnt 0,1,3,7 -> ch 0,1,2,3.
    slot(1'b1, 2'b01, 2'b00);
    slot(1'b0, 2'b01, 2'b00);
    slot(1'b0, 2'b00, 2'b00);
    slot(1'b0, 2'b01, 2'b00);
    slot(1'b0, 2'b00, 2'b00);
    slot(1'b0, 2'b00, 2'b00);
    slot(1'b0, 2'b00, 2'b00);
    slot(1'b0, 2'b01, 2'b00);
    repeat (3) slot(1'b0, 2'b00, 2'b00);
    check("decode_fill", 32'(fill), 32'd0);

    // Sparse Q event at ch=5 (cnt=31), including a pol-only violation later.
    slot(1'b1, 2'b00, 2'b00);
    while (tb_cnt != 31) slot(1'b0, 2'b00, 2'b00);
    slot(1'b0, 2'b00, 2'b11);
    slot(1'b0, 2'b10, 2'b00);
    repeat (3) slot(1'b0, 2'b00, 2'b00);

    // Backpressure: 10 qualifying slots into an 8-deep FIFO.
    rec_ready = 1'b0;
    slot(1'b1, 2'b01, 2'b00);
    repeat (9) slot(1'b0, 2'b01, 2'b00);
    check("bp_fill", 32'(fill), 32'd8);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_drop", 32'(drop_cnt), 32'd2);
    check("bp_valid", 32'(rec_valid), 32'd1);

    // Full FIFO with simultaneous push and pop: no drop, fill stays full.
    rec_ready = 1'b1;
    slot(1'b0, 2'b01, 2'b10);
    check("fullpop_fill", 32'(fill), 32'd8);
    check("fullpop_drop", 32'(drop_cnt), 32'd2);
    repeat (10) slot(1'b0, 2'b00, 2'b00);
    check("drain_fill", 32'(fill), 32'd0);
    check("sticky_overflow", 32'(overflow), 32'd1);
    check("model_drop", 32'(drop_cnt), 32'(m_drop));

    // Mid-stream reset discards buffered records and realigns to cnt=0.
    rec_ready = 1'b0;
    repeat (3) slot(1'b0, 2'b01, 2'b00);
    check("pre_rst_fill", 32'(fill), 32'd3);
    rst = 1'b1;
    @(posedge clk_master);
    @(negedge clk_master);
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_valid", 32'(rec_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    model_reset();
    rec_ready = 1'b1;
    slot(1'b0, 2'b01, 2'b00);
    repeat (3) slot(1'b0, 2'b00, 2'b00);

    // Bounded drain of anything still expected.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) slot(1'b0, 2'b00, 2'b00);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_all_q_empty", 32'(exp_all_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
